// File: rtl/edge_det_pkg.sv
// ---------------------------------------------------------------------------
// edge_det_pkg
// Shared types and helpers for the edge detector array.
//   edge_mode_e : per-channel edge selection (off / rise / fall / both)
//   slice_lo()  : low bit index of channel ch in a packed per-channel bus
// ---------------------------------------------------------------------------
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/edge_det_if.sv
// ---------------------------------------------------------------------------
// edge_det_if
// Bundles the per-channel control and status buses of edge_det_array.
//   din        : asynchronous level inputs, one bit per channel
//   mode       : 2 bits per channel, ch i at [2i+1:2i]
//   irq_en     : per-channel interrupt enable
//   status_clr : per-channel sticky status clear
//   cnt_clr    : per-channel edge counter clear
//   edge_p     : one-cycle pulse per qualified edge
//   status     : sticky edge-seen flags
//   edge_cnt   : CNT_W bits per channel, ch i at [CNT_W*(i+1)-1:CNT_W*i]
//   irq        : registered OR of enabled status bits
// master drives the controls, slave (the detector) drives the results.
// ---------------------------------------------------------------------------
interface edge_det_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       din;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       irq_en;
    logic [N_CH-1:0]       status_clr;
    logic [N_CH-1:0]       cnt_clr;
    logic [N_CH-1:0]       edge_p;
    logic [N_CH-1:0]       status;
    logic [N_CH*CNT_W-1:0] edge_cnt;
    logic                  irq;

    modport master (
        output din, mode, irq_en, status_clr, cnt_clr,
        input  edge_p, status, edge_cnt, irq
    );

    modport slave (
        input  din, mode, irq_en, status_clr, cnt_clr,
        output edge_p, status, edge_cnt, irq
    );
endinterface

// File: rtl/edge_det_chan.sv
// ---------------------------------------------------------------------------
// edge_det_chan
// One channel: synchroniser, glitch filter, edge qualification, sticky status
// and saturating edge counter.
//   clk, srst_n   : clock, synchronous active-low reset
//   din           : asynchronous level input
//   mode          : edge selection for this channel
//   status_clr    : clears the sticky status (set wins over clear)
//   cnt_clr       : clears the counter (a coincident edge leaves it at 1)
//   edge_p        : registered one-cycle pulse per qualified edge
//   status        : sticky edge-seen flag
//   status_next   : next-state of status, used by the top-level irq register
//   edge_cnt      : saturating edge count
// ---------------------------------------------------------------------------
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             din,
    input  edge_mode_e       mode,
    input  logic             status_clr,
    input  logic             cnt_clr,
    output logic             edge_p,
    output logic             status,
    output logic             status_next,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int                FCNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt;
    logic [FCNT_W-1:0]      fcnt;

    logic             sync;
    logic             accept;
    logic             rise;
    logic             fall;
    logic             edge_next;
    logic [CNT_W-1:0] cnt_next;

    // A new level is accepted once it has differed from filt for FILT_LEN
    // consecutive cycles; mode is only consulted at that moment, so a mode
    // change on its own can never produce an edge.
    always_comb begin
        sync        = sync_q[SYNC_STAGES-1];
        accept      = (sync != filt) && (fcnt == FCNT_LAST);
        rise        = accept & sync;
        fall        = accept & ~sync;
        edge_next   = (mode[0] & rise) | (mode[1] & fall);
        status_next = edge_next | (status & ~status_clr);

        cnt_next = edge_cnt;
        if (cnt_clr) begin
            cnt_next = edge_next ? CNT_W'(1) : '0;
        end else if (edge_next && (edge_cnt != CNT_MAX)) begin
            cnt_next = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            sync_q   <= '0;
            filt     <= 1'b0;
            fcnt     <= '0;
            edge_p   <= 1'b0;
            status   <= 1'b0;
            edge_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};

            // A bounce back to filt restarts the count without an event.
            if (sync == filt) begin
                fcnt <= '0;
            end else if (accept) begin
                filt <= sync;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FCNT_W'(1);
            end

            edge_p   <= edge_next;
            status   <= status_next;
            edge_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/edge_det_array.sv
// ---------------------------------------------------------------------------
// edge_det_array
// Multi-channel edge detector between the pad ring and the interrupt
// controller. Each channel is an independent edge_det_chan; irq is the
// registered OR of the enabled sticky status bits.
//   clk, srst_n : clock, synchronous active-low reset
//   bus         : edge_det_if slave port carrying all per-channel signals
// ---------------------------------------------------------------------------
module edge_det_array
    import edge_det_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 1,
    parameter int CNT_W       = 8
) (
    input logic        clk,
    input logic        srst_n,
    edge_det_if.slave  bus
);

    logic [N_CH-1:0]       edge_p_v;
    logic [N_CH-1:0]       status_v;
    logic [N_CH-1:0]       status_next_v;
    logic [N_CH*CNT_W-1:0] cnt_v;
    logic                  irq_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk         (clk),
            .srst_n      (srst_n),
            .din         (bus.din[i]),
            .mode        (edge_mode_e'(bus.mode[slice_lo(i, 2) +: 2])),
            .status_clr  (bus.status_clr[i]),
            .cnt_clr     (bus.cnt_clr[i]),
            .edge_p      (edge_p_v[i]),
            .status      (status_v[i]),
            .status_next (status_next_v[i]),
            .edge_cnt    (cnt_v[slice_lo(i, CNT_W) +: CNT_W])
        );
    end

    // Built from status_next so irq moves on the same edge as status itself.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status_next_v & bus.irq_en);
        end
    end

    assign bus.edge_p   = edge_p_v;
    assign bus.status   = status_v;
    assign bus.edge_cnt = cnt_v;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_edge_det_array.sv
// ---------------------------------------------------------------------------
// tb_edge_det_array
// Directed bench for edge_det_array. dut0 uses default parameters; dut1 uses
// FILT_LEN=4 and CNT_W=2 for the glitch-filter and saturation scenarios.
// ---------------------------------------------------------------------------
module tb_edge_det_array;

    logic clk;
    logic srst_n;

    int nChecks;
    int nFail;

    edge_det_if #(.N_CH(8), .CNT_W(8)) if0 ();
    edge_det_if #(.N_CH(8), .CNT_W(2)) if1 ();

    edge_det_array #(
        .N_CH(8), .SYNC_STAGES(2), .FILT_LEN(1), .CNT_W(8)
    ) dut0 (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (if0.slave)
    );

    edge_det_array #(
        .N_CH(8), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(2)
    ) dut1 (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock cycles, landing 1 time unit after the last rising edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n cycles on dut1 and count pulses seen on edge_p[ch].
    task automatic countPulses1(input int n, input int ch, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1);
            if (if1.edge_p[ch] === 1'b1) pulses++;
        end
    endtask

    // One rising-then-falling cycle on dut1 channel ch, each level long
    // enough to clear the 2-stage synchroniser and the 4-cycle filter.
    task automatic edgePair1(input int ch);
        if1.din[ch] = 1'b1;
        applyStimulus(6);
        if1.din[ch] = 1'b0;
        applyStimulus(6);
    endtask

    initial begin
        int p1;
        int p2;
        logic anyPulse;

        nChecks = 0;
        nFail   = 0;

        srst_n         = 1'b0;
        if0.din        = '0;
        if0.mode       = '0;
        if0.irq_en     = '0;
        if0.status_clr = '0;
        if0.cnt_clr    = '0;
        if1.din        = '0;
        if1.mode       = '0;
        if1.irq_en     = '0;
        if1.status_clr = '0;
        if1.cnt_clr    = '0;

        // ---- 1: reset with din toggling, then release with din low ----
        for (int k = 0; k < 4; k++) begin
            if0.din  = (k % 2 == 0) ? 8'hFF : 8'h00;
            if1.din  = (k % 2 == 0) ? 8'hFF : 8'h00;
            if0.mode = 16'hFFFF;
            if1.mode = 16'hFFFF;
            applyStimulus(1);
        end
        checkOutput("rst_edge_p0",  64'(if0.edge_p),   64'h0);
        checkOutput("rst_status0",  64'(if0.status),   64'h0);
        checkOutput("rst_cnt0",     64'(if0.edge_cnt), 64'h0);
        checkOutput("rst_irq0",     64'(if0.irq),      64'h0);
        checkOutput("rst_edge_p1",  64'(if1.edge_p),   64'h0);
        checkOutput("rst_cnt1",     64'(if1.edge_cnt), 64'h0);

        if0.din  = '0;
        if1.din  = '0;
        if0.mode = '0;
        if1.mode = '0;
        srst_n   = 1'b1;
        anyPulse = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1);
            anyPulse = anyPulse | (|if0.edge_p) | (|if1.edge_p);
        end
        checkOutput("rel_no_pulse", 64'(anyPulse), 64'h0);

        // ---- 2: ch0 rising edge latency, default parameters ----
        if0.mode = 16'h0001;
        if0.din[0] = 1'b1;
        applyStimulus(2);
        checkOutput("t2_early_edge_p", 64'(if0.edge_p[0]), 64'h0);
        applyStimulus(1);
        checkOutput("t2_edge_p",   64'(if0.edge_p),        64'h01);
        checkOutput("t2_status",   64'(if0.status),        64'h01);
        checkOutput("t2_cnt",      64'(if0.edge_cnt[7:0]), 64'h1);
        applyStimulus(1);
        checkOutput("t2_pulse_end", 64'(if0.edge_p[0]),    64'h0);
        if0.din[0] = 1'b0;
        anyPulse = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1);
            anyPulse = anyPulse | if0.edge_p[0];
        end
        checkOutput("t2_fall_no_pulse", 64'(anyPulse),          64'h0);
        checkOutput("t2_cnt_after",     64'(if0.edge_cnt[7:0]), 64'h1);

        // ---- 3: glitch filter, FILT_LEN=4, mode both on dut1 ch0 ----
        if1.mode = 16'h0003;
        if1.din[0] = 1'b1;
        countPulses1(3, 0, p1);
        if1.din[0] = 1'b0;
        countPulses1(10, 0, p2);
        checkOutput("t3_glitch_pulses", 64'(p1 + p2),           64'h0);
        checkOutput("t3_glitch_cnt",    64'(if1.edge_cnt[1:0]), 64'h0);

        if1.din[0] = 1'b1;
        countPulses1(4, 0, p1);
        if1.din[0] = 1'b0;
        countPulses1(12, 0, p2);
        checkOutput("t3_pulses", 64'(p1 + p2),           64'h2);
        checkOutput("t3_cnt",    64'(if1.edge_cnt[1:0]), 64'h2);
        checkOutput("t3_status", 64'(if1.status[0]),     64'h1);

        // ---- 4: saturation with CNT_W=2 on dut1 ch1, mode rise ----
        if1.mode = 16'h0007;
        for (int e = 0; e < 5; e++) begin
            edgePair1(1);
            if (e == 2) checkOutput("t4_cnt_3edges", 64'(if1.edge_cnt[3:2]), 64'h3);
        end
        checkOutput("t4_cnt_sat", 64'(if1.edge_cnt[3:2]), 64'h3);

        if1.din[1] = 1'b1;
        applyStimulus(5);
        if1.cnt_clr[1] = 1'b1;
        applyStimulus(1);
        if1.cnt_clr[1] = 1'b0;
        checkOutput("t4_edge_p_lat", 64'(if1.edge_p[1]),     64'h1);
        checkOutput("t4_clr_edge",   64'(if1.edge_cnt[3:2]), 64'h1);
        if1.din[1] = 1'b0;
        applyStimulus(6);
        if1.cnt_clr[1] = 1'b1;
        applyStimulus(1);
        if1.cnt_clr[1] = 1'b0;
        checkOutput("t4_clr_alone", 64'(if1.edge_cnt[3:2]), 64'h0);

        // ---- 5: set beats clear on dut0 ch2; irq tracks status ----
        if0.mode   = 16'h0011;
        if0.irq_en = 8'h04;
        applyStimulus(1);
        checkOutput("t5_irq_idle", 64'(if0.irq), 64'h0);
        if0.status_clr[2] = 1'b1;
        if0.din[2]        = 1'b1;
        applyStimulus(2);
        checkOutput("t5_status_pre", 64'(if0.status[2]), 64'h0);
        applyStimulus(1);
        checkOutput("t5_edge_p",     64'(if0.edge_p[2]), 64'h1);
        checkOutput("t5_set_wins",   64'(if0.status[2]), 64'h1);
        checkOutput("t5_irq_set",    64'(if0.irq),       64'h1);
        if0.status_clr[2] = 1'b0;
        applyStimulus(1);
        checkOutput("t5_status_hold", 64'(if0.status[2]), 64'h1);
        checkOutput("t5_irq_hold",    64'(if0.irq),       64'h1);
        if0.status_clr[2] = 1'b1;
        applyStimulus(1);
        if0.status_clr[2] = 1'b0;
        checkOutput("t5_status_clr", 64'(if0.status[2]), 64'h0);
        checkOutput("t5_irq_clr",    64'(if0.irq),       64'h0);
        checkOutput("t5_ch0_sticky", 64'(if0.status[0]), 64'h1);

        // ---- 6: all channels rise together on dut0 ----
        if0.mode       = 16'h5555;
        if0.irq_en     = 8'h00;
        if0.din        = 8'h00;
        if0.status_clr = 8'hFF;
        if0.cnt_clr    = 8'hFF;
        applyStimulus(4);
        if0.status_clr = 8'h00;
        if0.cnt_clr    = 8'h00;
        checkOutput("t6_status_clr", 64'(if0.status),   64'h0);
        checkOutput("t6_cnt_clr",    64'(if0.edge_cnt), 64'h0);
        if0.din = 8'hFF;
        applyStimulus(2);
        checkOutput("t6_early", 64'(if0.edge_p), 64'h00);
        applyStimulus(1);
        checkOutput("t6_edge_p_all", 64'(if0.edge_p), 64'hFF);
        applyStimulus(1);
        checkOutput("t6_pulse_end",  64'(if0.edge_p),           64'h00);
        checkOutput("t6_status_all", 64'(if0.status),           64'hFF);
        checkOutput("t6_cnt_ch7",    64'(if0.edge_cnt[63:56]),  64'h1);
        checkOutput("t6_irq_masked", 64'(if0.irq),              64'h0);
        if0.irq_en = 8'h20;
        applyStimulus(1);
        checkOutput("t6_irq_en5", 64'(if0.irq), 64'h1);
        if0.irq_en = 8'h00;
        applyStimulus(1);
        checkOutput("t6_irq_drop", 64'(if0.irq), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
